// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read channel: one request at a time over ready/valid,
// with read data returned on a separate rvalid strobe.
interface instruction_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues single outstanding imem reads and
// holds the fetched instruction for decode, honouring stalls and redirects.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall_i,
  input  logic                             redirect_valid_i,
  input  logic [31:0]                      redirect_pc_i,
  instruction_fetch_unit_if.master         imem,
  output logic [31:0]                      instruction_out_o,
  output logic [31:0]                      pc_o,
  output logic [31:0]                      pc_p_four_o,
  output logic                             fetch_valid_o
);

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] target_s;

  assign target_s = redirect_pc_i & ~32'd3;

  // Request is combinational on state so it drops immediately while reset is held.
  assign imem.imem_req  = (state_q == REQ) && !rst;
  assign imem.imem_addr = pc_f_q;

  assign instruction_out_o = instr_q;
  assign pc_o              = pc_q;
  assign pc_p_four_o       = pc4_q;
  assign fetch_valid_o     = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      pc_f_q  <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC + 32'd4;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_f_q  <= pc_f_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_f_d  = pc_f_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (state_q)
      REQ: begin
        if (redirect_valid_i) begin
          pc_f_d = target_s;
          // An accepted request must still have its response drained.
          if (imem.imem_ready) state_d = DISCARD;
        end else if (imem.imem_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid_i) begin
          pc_f_d  = target_s;
          state_d = imem.imem_rvalid ? REQ : DISCARD;
        end else if (imem.imem_rvalid) begin
          instr_d = imem.imem_rdata;
          pc_d    = pc_f_q;
          pc4_d   = pc_f_q + 32'd4;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      DISCARD: begin
        if (redirect_valid_i) pc_f_d = target_s;
        if (imem.imem_rvalid) state_d = REQ;
      end
      HOLD: begin
        if (redirect_valid_i) begin
          pc_f_d  = target_s;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = REQ;
        end else if (!stall_i) begin
          pc_f_d  = pc_f_q + 32'd4;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch-stage producer for the fetch/decode pipeline register. It owns the fetch PC, issues one instruction-memory read at a time over a ready/valid handshake, and presents `instruction_out`, `pc`, `pc_p_four` with a `fetch_valid` qualifier to the fetch/decode register. It honours decode-side stalls and execute-side redirects (branch/jump), and discards any in-flight fetch made stale by a redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset; word aligned.
- `NOP_INSTR`, 32'h0000_0013, value driven on `instruction_out` when no valid fetch is held (`addi x0,x0,0`).

- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `stall`  in  1  decode cannot accept; the held fetch must not advance.
- `redirect_valid`  in  1  execute requests a PC change this cycle.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `imem_req`  out  1  read request valid.
- `imem_addr`  out  32  read address, equal to the fetch PC `pc_f`.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  read data.
- `instruction_out`  out  32  fetched instruction.
- `pc`  out  32  address of `instruction_out`.
- `pc_p_four`  out  32  `pc + 4`, modulo 2^32.
- `fetch_valid`  out  1  `instruction_out`/`pc`/`pc_p_four` are valid.

## Operation
- States: REQ, WAIT, DISCARD, HOLD. Internal register `pc_f` holds the fetch PC.
- Reset values:
  - state=REQ, `pc_f`=RESET_PC, `fetch_valid`=0.
  - `instruction_out`=NOP_INSTR, `pc`=RESET_PC, `pc_p_four`=RESET_PC+4.
  - `imem_req` is 0 while `rst` is high.
- `imem_req` = 1 only in REQ (and not in reset). `imem_addr` = `pc_f` at all times.
- REQ:
  - `redirect_valid` && `imem_ready`: `pc_f`←target, go to DISCARD (the old request was accepted and its data must be dropped).
  - `redirect_valid` && !`imem_ready`: `pc_f`←target, stay in REQ.
  - `imem_ready` alone: go to WAIT.
- WAIT:
  - `redirect_valid`: `pc_f`←target. Go to REQ if `imem_rvalid` is also high (data dropped), otherwise go to DISCARD.
  - `imem_rvalid` alone: latch `instruction_out`←`imem_rdata`, `pc`←`pc_f`, `pc_p_four`←`pc_f`+4; set `fetch_valid`=1; go to HOLD.
- DISCARD: on `imem_rvalid`, drop the data and go to REQ. A `redirect_valid` here updates `pc_f` only and does not change state.
- HOLD:
  - `redirect_valid`: `pc_f`←target, `fetch_valid`←0, outputs←NOP_INSTR, go to REQ.
  - Otherwise, if !`stall`: `pc_f`←`pc_f`+4, `fetch_valid`←0, go to REQ.
  - Otherwise (`stall`): hold every output unchanged.
- Priority: `rst` > `redirect_valid` > `stall`. `stall` has no effect outside HOLD.
- Consumption: the downstream register takes the instruction on a rising edge where `fetch_valid` && !`stall`.
- At most one memory request is outstanding. PC arithmetic wraps modulo 2^32.

## Timing
- Best-case issue rate is one instruction per 3 cycles: REQ (accepted) → WAIT (`rvalid` the same cycle as entering WAIT) → HOLD.
- `fetch_valid` rises on the edge that samples `imem_rvalid` in WAIT, so it is visible the following cycle.
- `imem_rvalid` is only legal one or more cycles after the accepting cycle. `imem_rvalid` outside WAIT/DISCARD is ignored.
- Redirect latency: the new target appears on `imem_addr` the cycle after `redirect_valid` is sampled.
- Reset mid-operation: all state returns to reset values at the next edge. An in-flight response arriving after reset is sampled in REQ and ignored.

## Test plan
- Reset, then memory with `imem_ready`=1 and `rvalid` one cycle later returning 0x00500093 → `imem_addr`=0x0; `fetch_valid`=1 with `pc`=0x0, `pc_p_four`=0x4; next `imem_addr`=0x4.
- `stall` held 3 cycles in HOLD at `pc`=0x8 → outputs are stable and `imem_req`=0 for all 3 cycles; after release, `imem_addr`=0xC.
- `redirect_valid` with `redirect_pc`=0x103 while in WAIT for 0x10 → the 0x10 data is dropped, `imem_addr`=0x100, and the next valid fetch has `pc`=0x100.
- `redirect_valid` and `imem_ready` in the same REQ cycle (target 0x40) → DISCARD consumes one `rvalid`; the next request goes to 0x40.
- `redirect_valid` and `stall` together in HOLD → `fetch_valid` drops and the fetch restarts at the target.
- `RESET_PC`=0xFFFFFFFC → `pc_p_four`=0x0 and the second `imem_addr`=0x0; asserting `rst` in WAIT → `imem_addr`=RESET_PC and `fetch_valid`=0.
